bitwise_logic_unit: RTL and testbench



---
 rtl/bitwise_logic_unit.sv | 146 ++++++++++++++
 tb/tb_bitwise_logic_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
// Sequential bitwise logic unit: eight ops on WIDTH-bit operands, CHUNK bits per cycle, valid/ready on both sides.
// Optional zero/ones result flags are enabled by defining BWLU_FLAGS_EN.
module bitwise_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BWLU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ones
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("bitwise_logic_unit: WIDTH must be >= 1 and an exact multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [2:0]       opr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic             chunk_last;

    function automatic logic [CHUNK-1:0] apply_op(input logic [2:0] f,
                                                  input logic [CHUNK-1:0] a,
                                                  input logic [CHUNK-1:0] b);
        logic [CHUNK-1:0] r;
        case (f)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

    assign chunk_last = (cnt == CW'(NCHUNK - 1));
    assign in_ready   = (state == IDLE);

    // Work register with the current chunk's result merged in
    always_comb begin
        work_nxt = work;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            if (cnt == CW'(i)) begin
                work_nxt[i*CHUNK +: CHUNK] = apply_op(opr, xr[i*CHUNK +: CHUNK], yr[i*CHUNK +: CHUNK]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (chunk_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, chunk processing and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            xr        <= '0;
            yr        <= '0;
            opr       <= '0;
            cnt       <= '0;
            work      <= '0;
            o         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                xr  <= x;
                yr  <= y;
                opr <= op;
                cnt <= '0;
            end
            if (state == BUSY) begin
                work <= work_nxt;
                if (chunk_last) begin
                    cnt <= '0;
                    o   <= work_nxt;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            out_valid <= (state_nxt == DONE);
        end
    end

`ifdef BWLU_FLAGS_EN
    // Flags follow o: loaded only on the BUSY->DONE edge
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            ones <= 1'b0;
        end else if (state == BUSY && chunk_last) begin
            zero <= ~|work_nxt;
            ones <= &work_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit: an 8-bit/2-bit-chunk instance and a 4-bit single-chunk instance.
module tb_bitwise_logic_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x, y, o;
    logic [2:0] op;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] x4, y4, o4;
    logic [2:0] op4;
    logic       iv4, ir4, ov4, or4;
`ifdef BWLU_FLAGS_EN
    logic       zero, ones, zero4, ones4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .rst(rst), .x(x), .y(y), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .o(o), .out_valid(out_valid), .out_ready(out_ready)
`ifdef BWLU_FLAGS_EN
        , .zero(zero), .ones(ones)
`endif
    );

    bitwise_logic_unit #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .x(x4), .y(y4), .op(op4),
        .in_valid(iv4), .in_ready(ir4),
        .o(o4), .out_valid(ov4), .out_ready(or4)
`ifdef BWLU_FLAGS_EN
        , .zero(zero4), .ones(ones4)
`endif
    );

    function automatic logic [7:0] ref_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return a;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on the 8-bit unit and count edges until out_valid (bounded)
    task automatic run_op8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b, output int lat);
        op = f; x = a; y = b; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; x = 8'hFF; y = 8'hFF; op = 3'd1;
        iv4 = 1'b1; or4 = 1'b0; x4 = 4'h0; y4 = 4'h0; op4 = 3'd0;
        tick;
        tick;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (o !== 8'h00) begin errors++; $display("FAIL reset_o: got %h expected 00", o); end
        checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1 || o4 !== 4'h0) begin
            errors++; $display("FAIL reset_dut4: got ov=%b ir=%b o=%h expected 0 1 0", ov4, ir4, o4); end
`ifdef BWLU_FLAGS_EN
        checks++; if (zero !== 1'b0 || ones !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", zero, ones); end
`endif
        rst = 1'b0; in_valid = 1'b0; iv4 = 1'b0;
        tick;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_no_capture: got in_ready %b expected 1", in_ready); end
    endtask

    task automatic test_and;
        op = 3'd0; x = 8'hCA; y = 8'h5F; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; x = 8'h00; y = 8'h00;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL and_in_ready_drop: got %b expected 0", in_ready); end
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++; if (out_valid !== 1'b0 || o !== 8'h00) begin
                errors++; $display("FAIL and_busy_%0d: got ov=%b o=%h expected 0 00", k, out_valid, o); end
        end
        tick;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_latency: got out_valid %b expected 1", out_valid); end
        checks++; if (o !== 8'h4A) begin errors++; $display("FAIL and_result: got %h expected 4a", o); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || o !== 8'h4A) begin
            errors++; $display("FAIL and_handshake: got ir=%b ov=%b o=%h expected 1 0 4a", in_ready, out_valid, o); end
    endtask

    task automatic test_backpressure;
        int lat;
        run_op8(3'd2, 8'hA5, 8'hFF, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        checks++; if (o !== 8'h5A) begin errors++; $display("FAIL bp_result: got %h expected 5a", o); end
        in_valid = 1'b1; x = 8'h00; y = 8'h00; op = 3'd1;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (out_valid !== 1'b1 || o !== 8'h5A || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got ov=%b o=%h ir=%b expected 1 5a 0", k, out_valid, o, in_ready); end
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || o !== 8'h5A) begin
            errors++; $display("FAIL bp_release: got ir=%b ov=%b o=%h expected 1 0 5a", in_ready, out_valid, o); end
    endtask

    task automatic test_reset_mid;
        int lat;
        op = 3'd1; x = 8'h0F; y = 8'hF0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || o !== 8'h00) begin
            errors++; $display("FAIL midrst_outputs: got ov=%b o=%h expected 0 00", out_valid, o); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        run_op8(3'd6, 8'hFF, 8'h0F, lat);
        checks++; if (lat !== 4 || o !== 8'hF0) begin
            errors++; $display("FAIL midrst_fresh_op: got lat=%0d o=%h expected 4 f0", lat, o); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_single_chunk;
        logic [7:0] r;
        logic [3:0] exp4;
        for (int f = 0; f < 8; f++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    op4 = 3'(f); x4 = 4'(a); y4 = 4'(b); iv4 = 1'b1;
                    tick;
                    iv4 = 1'b0; x4 = ~x4;
                    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL w4_early_%0d_%0d_%0d: got ov=1 expected 0", f, a, b); end
                    tick;
                    r = ref_op(3'(f), {4'h0, 4'(a)}, {4'h0, 4'(b)});
                    exp4 = r[3:0];
                    checks++; if (ov4 !== 1'b1 || o4 !== exp4) begin
                        errors++; $display("FAIL w4_op_%0d_%0d_%0d: got ov=%b o=%h expected 1 %h", f, a, b, ov4, o4, exp4); end
                    if (f == 0) begin
                        checks++; if (o4 !== (4'(a) & 4'(b))) begin
                            errors++; $display("FAIL w4_legacy_and_%0d_%0d: got %h expected %h", a, b, o4, 4'(a) & 4'(b)); end
                    end
                    or4 = 1'b1;
                    tick;
                    or4 = 1'b0;
                end
            end
        end
    endtask

    task automatic test_flags;
        int lat;
        run_op8(3'd0, 8'h00, 8'hFF, lat);
        checks++; if (o !== 8'h00) begin errors++; $display("FAIL flags_and_o: got %h expected 00", o); end
`ifdef BWLU_FLAGS_EN
        checks++; if (zero !== 1'b1 || ones !== 1'b0) begin errors++; $display("FAIL flags_and: got z=%b o=%b expected 1 0", zero, ones); end
`endif
        out_ready = 1'b1; tick; out_ready = 1'b0;
        run_op8(3'd1, 8'h00, 8'hFF, lat);
        checks++; if (o !== 8'hFF) begin errors++; $display("FAIL flags_or_o: got %h expected ff", o); end
`ifdef BWLU_FLAGS_EN
        checks++; if (zero !== 1'b0 || ones !== 1'b1) begin errors++; $display("FAIL flags_or: got z=%b o=%b expected 0 1", zero, ones); end
`endif
        out_ready = 1'b1; tick; out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] vx [10];
        logic [7:0] vy [10];
        logic [2:0] vop [10];
        logic [7:0] exp;
        int k = 0;
        int cyc = 0;
        int last_done = 0;
        for (int i = 0; i < 10; i++) begin
            vx[i] = 8'($urandom); vy[i] = 8'($urandom); vop[i] = 3'($urandom_range(7, 0));
        end
        out_ready = 1'b1; in_valid = 1'b1;
        x = vx[0]; y = vy[0]; op = vop[0];
        while (k < 10 && cyc < 200) begin
            tick;
            cyc++;
            if (out_valid) begin
                exp = ref_op(vop[k], vx[k], vy[k]);
                checks++; if (o !== exp) begin errors++; $display("FAIL b2b_result_%0d: got %h expected %h", k, o, exp); end
                if (k > 0) begin
                    checks++; if (cyc - last_done !== 6) begin
                        errors++; $display("FAIL b2b_period_%0d: got %0d expected 6", k, cyc - last_done); end
                end
                last_done = cyc;
                k++;
            end
            // Garbage operands while busy must not disturb the operation in flight
            if (!in_ready && !out_valid) begin
                x = 8'($urandom); y = 8'($urandom); op = 3'($urandom_range(7, 0));
            end else if (k < 10) begin
                x = vx[k]; y = vy[k]; op = vop[k];
            end
        end
        checks++; if (k !== 10) begin errors++; $display("FAIL b2b_timeout: got %0d results expected 10", k); end
        in_valid = 1'b0;
        tick;
        out_ready = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_and;
        test_backpressure;
        test_reset_mid;
        test_single_chunk;
        test_flags;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
